// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// wb_cmd_t is the registered write command driven into the register file's write port.
package regfile_pkg;

    localparam int XLEN          = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic            we;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_cmd_t;

    // Decoded one-hot mask for a register index, used for scoreboard set/clear.
    function automatic logic [NUM_ARCH_REGS-1:0] reg_mask(input reg_idx_t idx, input logic en);
        logic [NUM_ARCH_REGS-1:0] m;
        m = NUM_ARCH_REGS'(1) << idx;
        return en ? m : {NUM_ARCH_REGS{1'b0}};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; owns the priority pointer.
// The pointer moves to the granted index only on a cycle where a grant is issued.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] gnt_idx_s;
    logic [N-1:0]  gnt_s;
    logic          found_s;
    int            idx_s;

    // Search from ptr+1 with wrap; first valid requester wins.
    always_comb begin
        gnt_s     = {N{1'b0}};
        gnt_idx_s = ptr_r;
        found_s   = 1'b0;
        idx_s     = 0;
        if (!rst && !hold) begin
            for (int k = 1; k <= N; k++) begin
                idx_s = (int'(ptr_r) + k) % N;
                if (!found_s && req[idx_s]) begin
                    found_s        = 1'b1;
                    gnt_s[idx_s]   = 1'b1;
                    gnt_idx_s      = PW'(idx_s);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            gnt_s = {N{1'b0}};
        end
    end

    // Priority pointer; reset value makes requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= PW'(N - 1);
        end else if (found_s) begin
            ptr_r <= gnt_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant, registered write port, optional
// pending-write scoreboard enabled by macro REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          hold,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_rd,
    output logic [XLEN-1:0]               rf_data
`ifdef REGFILE_WB_SCOREBOARD_EN
    ,
    input  logic                          sb_set_valid,
    input  logic [REG_ADDR_W-1:0]         sb_set_rd,
    input  logic                          sb_flush,
    input  logic [REG_ADDR_W-1:0]         rs1,
    input  logic [REG_ADDR_W-1:0]         rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy
`endif
);

    import regfile_pkg::*;

    logic [NUM_REQ-1:0]    gnt_s;
    logic                  hs_s;
    logic [REG_ADDR_W-1:0] sel_rd_s;
    logic [XLEN-1:0]       sel_data_s;
    wb_cmd_t               cmd_r;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (req_valid),
        .hold (hold),
        .gnt  (gnt_s)
    );

    assign req_ready = gnt_s;
    assign hs_s      = |gnt_s;

    // AND-OR mux keyed by the one-hot grant.
    always_comb begin
        sel_rd_s   = {REG_ADDR_W{1'b0}};
        sel_data_s = {XLEN{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rd_s   = sel_rd_s   | (req_rd[i*REG_ADDR_W +: REG_ADDR_W] & {REG_ADDR_W{gnt_s[i]}});
            sel_data_s = sel_data_s | (req_data[i*XLEN +: XLEN] & {XLEN{gnt_s[i]}});
        end
    end

    // Output write register; an x0 handshake is consumed without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r <= '0;
        end else if (hs_s && (sel_rd_s != {REG_ADDR_W{1'b0}})) begin
            cmd_r.we   <= 1'b1;
            cmd_r.rd   <= sel_rd_s;
            cmd_r.data <= sel_data_s;
        end else begin
            cmd_r.we   <= 1'b0;
        end
    end

    assign rf_we   = cmd_r.we;
    assign rf_rd   = cmd_r.rd;
    assign rf_data = cmd_r.data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUM_ARCH_REGS-1:0] busy_r;
    logic [NUM_ARCH_REGS-1:0] busy_nxt_s;
    logic [NUM_ARCH_REGS-1:0] set_mask_s;
    logic [NUM_ARCH_REGS-1:0] clr_mask_s;

    // Set beats clear for the same rd; flush beats both; bit 0 never sets.
    always_comb begin
        set_mask_s = reg_mask(sb_set_rd, sb_set_valid && (sb_set_rd != {REG_ADDR_W{1'b0}}));
        clr_mask_s = reg_mask(cmd_r.rd, cmd_r.we);
        busy_nxt_s = sb_flush ? {NUM_ARCH_REGS{1'b0}}
                              : (((busy_r & ~clr_mask_s) | set_mask_s) & ~NUM_ARCH_REGS'(1));
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NUM_ARCH_REGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign rs1_busy = busy_r[rs1];
    assign rs2_busy = busy_r[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; scoreboard scenarios run only
// when REGFILE_WB_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int XL = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_rd;
    logic [NR*XL-1:0]  req_data;
    logic              hold;
    logic              rf_we;
    logic [AW-1:0]     rf_rd;
    logic [XL-1:0]     rf_data;
`ifdef REGFILE_WB_SCOREBOARD_EN
    logic              sb_set_valid;
    logic [AW-1:0]     sb_set_rd;
    logic              sb_flush;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              rs1_busy;
    logic              rs2_busy;
`endif

    logic [AW-1:0] rd_v  [NR];
    logic [XL-1:0] dat_v [NR];

    always_comb begin
        req_rd   = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_rd[i*AW +: AW]   = rd_v[i];
            req_data[i*XL +: XL] = dat_v[i];
        end
    end

    regfile_wb_arbiter #(
        .NUM_REQ    (NR),
        .XLEN       (XL),
        .REG_ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data)
`ifdef REGFILE_WB_SCOREBOARD_EN
        ,
        .sb_set_valid (sb_set_valid),
        .sb_set_rd    (sb_set_rd),
        .sb_flush     (sb_flush),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
`endif
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [XL-1:0] data;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] last_rd;
    logic [XL-1:0] last_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check grant at negedge, queue the expected write, check it after posedge.
    task automatic cycle(input logic [NR-1:0] exp_rdy, input string tag);
        exp_t e;
        int   idx;
        @(negedge clk);
        chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
        idx = -1;
        for (int i = 0; i < NR; i++) begin
            if (exp_rdy[i]) idx = i;
        end
        if (idx >= 0 && rd_v[idx] != '0) begin
            last_rd   = rd_v[idx];
            last_data = dat_v[idx];
            e.we      = 1'b1;
        end else begin
            e.we      = 1'b0;
        end
        e.rd   = last_rd;
        e.data = last_data;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, ".queue"}, 64'(0), 64'(1));
        end else begin
            e = q.pop_front();
            chk({tag, ".rf_we"},   64'(rf_we),   64'(e.we));
            chk({tag, ".rf_rd"},   64'(rf_rd),   64'(e.rd));
            chk({tag, ".rf_data"}, 64'(rf_data), 64'(e.data));
        end
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '1;
        last_rd   = '0;
        last_data = '0;
        for (int i = 0; i < NR; i++) begin
            rd_v[i]  = AW'(10 + i);
            dat_v[i] = 32'hC0DE_0000 + XL'(i);
        end
`ifdef REGFILE_WB_SCOREBOARD_EN
        sb_set_valid = 1'b0;
        sb_set_rd    = '0;
        sb_flush     = 1'b0;
        rs1          = 5'd0;
        rs2          = 5'd0;
`endif

        // Reset state
        #12;
        chk("rst.ready",   64'(req_ready), 64'(0));
        chk("rst.rf_we",   64'(rf_we),     64'(0));
        chk("rst.rf_rd",   64'(rf_rd),     64'(0));
        chk("rst.rf_data", 64'(rf_data),   64'(0));
`ifdef REGFILE_WB_SCOREBOARD_EN
        rs1 = 5'd10;
        rs2 = 5'd31;
        #1;
        chk("rst.rs1_busy", 64'(rs1_busy), 64'(0));
        chk("rst.rs2_busy", 64'(rs2_busy), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin with all requesters continuously valid
        for (int k = 0; k < 6; k++) begin
            cycle(NR'(1) << (k % 3), "rr");
        end

        // Hold blocks grants, then an x0 handshake writes nothing
        hold      = 1'b1;
        req_valid = 3'b010;
        rd_v[1]   = 5'd0;
        dat_v[1]  = 32'h1234_5678;
        cycle(3'b000, "hold0");
        cycle(3'b000, "hold1");
        hold = 1'b0;
        cycle(3'b010, "x0");
        req_valid = 3'b000;
        cycle(3'b000, "idle0");

        // Reset while a write is on the port
        req_valid = 3'b001;
        rd_v[0]   = 5'd3;
        dat_v[0]  = 32'hAAAA_5555;
        cycle(3'b001, "pre_rst");
        req_valid = 3'b111;
        rd_v[1]   = 5'd11;
        rst       = 1'b1;
        #2;
        chk("midrst.rf_we",   64'(rf_we),     64'(0));
        chk("midrst.rf_rd",   64'(rf_rd),     64'(0));
        chk("midrst.rf_data", 64'(rf_data),   64'(0));
        chk("midrst.ready",   64'(req_ready), 64'(0));
        last_rd   = '0;
        last_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(3'b001, "post_rst");
        req_valid = 3'b000;
        cycle(3'b000, "idle1");

`ifdef REGFILE_WB_SCOREBOARD_EN
        // Pending bit set, held through the write cycle, cleared after
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd5;
        cycle(3'b000, "sb_set5");
        sb_set_valid = 1'b0;
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        chk("sb.busy5_set", 64'(rs1_busy), 64'(1));
        chk("sb.x0_idle",   64'(rs2_busy), 64'(0));
        req_valid = 3'b001;
        rd_v[0]   = 5'd5;
        dat_v[0]  = 32'hDEAD_BEEF;
        cycle(3'b001, "sb_wr5");
        chk("sb.busy5_wecyc", 64'(rs1_busy), 64'(1));
        req_valid = 3'b000;
        cycle(3'b000, "sb_after5");
        chk("sb.busy5_clr", 64'(rs1_busy), 64'(0));

        // Same-cycle set and clear of rd 7, then flush overriding a set
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd7;
        cycle(3'b000, "sb_set7");
        sb_set_valid = 1'b0;
        rs2 = 5'd7;
        #1;
        chk("sb.busy7_set", 64'(rs2_busy), 64'(1));
        req_valid = 3'b001;
        rd_v[0]   = 5'd7;
        dat_v[0]  = 32'h0000_0777;
        cycle(3'b001, "sb_wr7");
        req_valid    = 3'b000;
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd7;
        cycle(3'b000, "sb_conflict");
        sb_set_valid = 1'b0;
        #1;
        chk("sb.busy7_conflict", 64'(rs2_busy), 64'(1));
        sb_flush     = 1'b1;
        sb_set_valid = 1'b1;
        sb_set_rd    = 5'd9;
        cycle(3'b000, "sb_flush");
        sb_flush     = 1'b0;
        sb_set_valid = 1'b0;
        rs1 = 5'd9;
        #1;
        chk("sb.flush9", 64'(rs1_busy), 64'(0));
        chk("sb.flush7", 64'(rs2_busy), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
